// File: rtl/lcd_ctrl.sv
// HD44780 bus-cycle engine: turns GO-toggle requests into setup/EN/hold/wait sequences.
// Optional power-on init sequence is built when LCD_INIT_EN is defined.
module lcd_ctrl #(
    parameter int SETUP_CYC     = 3,
    parameter int EN_CYC        = 25,
    parameter int HOLD_CYC      = 3,
    parameter int CMD_WAIT_CYC  = 2500,
    parameter int LONG_WAIT_CYC = 82000,
    parameter int PWR_WAIT_CYC  = 750000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lcd_word_i,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        overrun_o,
    output logic        lcd_on_o,
    output logic        lcd_blon_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic [7:0]  lcd_data_o,
    output logic [2:0]  state_o
);

    localparam int M1 = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int M2 = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
    localparam int M3 = (M2 > CMD_WAIT_CYC) ? M2 : CMD_WAIT_CYC;
    localparam int M4 = (M3 > LONG_WAIT_CYC) ? M3 : LONG_WAIT_CYC;
    localparam int M5 = (M4 > PWR_WAIT_CYC) ? M4 : PWR_WAIT_CYC;
    localparam int CW = $clog2(M5) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT, S_PWR_WAIT, S_INIT_ISSUE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            go_q, req;
    logic            rs_q, rs_d, long_q, long_d, overrun_q, overrun_d;
    logic [7:0]      data_q, data_d;
    logic            on_q, blon_q;
    logic            unused_word_bits;

    assign unused_word_bits = ^{lcd_word_i[28:10], lcd_word_i[8]};
    assign req = lcd_word_i[30] ^ go_q;

`ifdef LCD_INIT_EN
    logic [2:0] idx_q, idx_d;
    logic       done_q, done_d;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
            3'd3:             init_cmd = 8'h0C;
            3'd4:             init_cmd = 8'h01;
            default:          init_cmd = 8'h06;
        endcase
    endfunction

    assign init_done_o = done_q;
`else
    assign init_done_o = 1'b1;
`endif

    // go_q follows the word even in reset so a held toggle never fires afterwards.
    always_ff @(posedge clk_i) begin
        go_q <= lcd_word_i[30];
        if (rst_i) begin
`ifdef LCD_INIT_EN
            state_q <= S_PWR_WAIT;
            cnt_q   <= CW'(PWR_WAIT_CYC - 1);
            idx_q   <= 3'd0;
            done_q  <= 1'b0;
`else
            state_q <= S_IDLE;
            cnt_q   <= '0;
`endif
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            long_q    <= 1'b0;
            overrun_q <= 1'b0;
            on_q      <= 1'b0;
            blon_q    <= 1'b0;
        end else begin
`ifdef LCD_INIT_EN
            idx_q  <= idx_d;
            done_q <= done_d;
`endif
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
            long_q    <= long_d;
            overrun_q <= overrun_d;
            on_q      <= lcd_word_i[31];
            blon_q    <= lcd_word_i[29];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - 1'b1;
        rs_d      = rs_q;
        data_d    = data_q;
        long_d    = long_q;
        overrun_d = overrun_q | (req && (state_q != S_IDLE));
`ifdef LCD_INIT_EN
        idx_d  = idx_q;
        done_d = done_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (req) begin
                    rs_d    = lcd_word_i[9];
                    data_d  = lcd_word_i[7:0];
                    long_d  = !lcd_word_i[9] && (lcd_word_i[7:0] inside {8'h01, 8'h02, 8'h03});
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                end
            end
            S_SETUP: if (cnt_q == '0) begin
                state_d = S_EN_HI;
                cnt_d   = CW'(EN_CYC - 1);
            end
            S_EN_HI: if (cnt_q == '0) begin
                state_d = S_HOLD;
                cnt_d   = CW'(HOLD_CYC - 1);
            end
            S_HOLD: if (cnt_q == '0) begin
                state_d = S_WAIT;
                cnt_d   = long_q ? CW'(LONG_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
            end
            S_WAIT: if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
                if (!done_q && idx_q != 3'd5) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_INIT_ISSUE;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
`ifdef LCD_INIT_EN
            S_PWR_WAIT: if (cnt_q == '0) state_d = S_INIT_ISSUE;
            S_INIT_ISSUE: begin
                rs_d    = 1'b0;
                data_d  = init_cmd(idx_q);
                long_d  = (init_cmd(idx_q) == 8'h01);
                state_d = S_SETUP;
                cnt_d   = CW'(SETUP_CYC - 1);
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign lcd_en_o   = (state_q == S_EN_HI);
    assign lcd_rw_o   = 1'b0;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;
    assign overrun_o  = overrun_q;
    assign lcd_on_o   = on_q;
    assign lcd_blon_o = blon_q;
    assign state_o    = state_q;

endmodule
